// File: rtl/float_floor_if.sv
// Operand/result stream bundle for the floor unit: operand in with valid/ready,
// result out with valid/ready. master = producer/consumer side, slave = the unit.
interface float_floor_if;
  logic [31:0] in_a;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_z;
  logic        out_inexact;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_a, in_valid, out_ready,
    input  in_ready, out_z, out_inexact, out_valid
  );

  modport slave (
    input  in_a, in_valid, out_ready,
    output in_ready, out_z, out_inexact, out_valid
  );
endinterface

// File: rtl/float_floor.sv
// IEEE-754 single floor (round toward -inf), 3-stage pipeline: unpack, mask/select, add/pack.
// Latency 3 edges from accept; a stalled output freezes every stage (in_ready drops).
module float_floor #(
  parameter bit QUIET_NAN = 1'b1,
  parameter bit DAZ       = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  float_floor_if.slave bus
);

  typedef enum logic [2:0] {
    K_PASS,
    K_NAN,
    K_ZERO,
    K_SMALL,
    K_MID
  } kind_t;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------- S1: classify ----------------
  kind_t       kind_in;
  logic [7:0]  e_in;
  logic [22:0] f_in;

  assign e_in = bus.in_a[30:23];
  assign f_in = bus.in_a[22:0];

  always_comb begin
    kind_in = K_PASS;
    if (e_in == 8'hFF) begin
      kind_in = (f_in != 23'd0) ? K_NAN : K_PASS;
    end else if (e_in >= 8'd150) begin
      kind_in = K_PASS;
    end else if (e_in == 8'd0) begin
      if (f_in == 23'd0) kind_in = K_PASS;
      else               kind_in = DAZ ? K_ZERO : K_SMALL;
    end else if (e_in < 8'd127) begin
      kind_in = K_SMALL;
    end else begin
      kind_in = K_MID;
    end
  end

  logic        v1;
  logic [31:0] a1;
  kind_t       k1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= 32'd0;
      k1 <= K_PASS;
    end else if (adv) begin
      v1 <= bus.in_valid;
      a1 <= bus.in_a;
      k1 <= kind_in;
    end
  end

  // ---------------- S2: mask and adjust select ----------------
  // For e in 127..149, E = e-127 equals e[4:0]+1 modulo 32.
  logic [4:0]  sh;
  logic [22:0] mask;
  logic [31:0] base_c;
  logic [30:0] add_c;
  logic        ix_c;

  assign sh   = a1[27:23] + 5'd1;
  assign mask = 23'h7FFFFF >> sh;

  always_comb begin
    base_c = a1;
    add_c  = 31'd0;
    ix_c   = 1'b0;
    unique case (k1)
      K_NAN:   base_c = a1 | (QUIET_NAN ? 32'h0040_0000 : 32'h0);
      K_ZERO:  base_c = {a1[31], 31'd0};
      K_SMALL: begin
        base_c = a1[31] ? 32'hBF80_0000 : 32'h0000_0000;
        ix_c   = 1'b1;
      end
      K_MID: begin
        if ((a1[22:0] & mask) != 23'd0) begin
          base_c = {a1[31:23], a1[22:0] & ~mask};
          ix_c   = 1'b1;
          // Negative values step down one unit; the carry may ripple into the exponent.
          if (a1[31]) add_c = {7'd0, {1'b0, mask} + 24'd1};
        end
      end
      default: ;
    endcase
  end

  logic        v2;
  logic [31:0] base2;
  logic [30:0] add2;
  logic        ix2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      base2 <= 32'd0;
      add2  <= 31'd0;
      ix2   <= 1'b0;
    end else if (adv) begin
      v2    <= v1;
      base2 <= base_c;
      add2  <= add_c;
      ix2   <= ix_c;
    end
  end

  // ---------------- S3: add and pack into output registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_z       <= 32'd0;
      bus.out_inexact <= 1'b0;
    end else if (adv) begin
      bus.out_valid   <= v2;
      bus.out_z       <= {base2[31], base2[30:0] + add2};
      bus.out_inexact <= ix2;
    end
  end

endmodule

// File: tb/tb_float_floor.sv
// Scoreboard bench for float_floor: two instances (QUIET_NAN=1/DAZ=0 and QUIET_NAN=0/DAZ=1)
// driven in lockstep; expected results are queued at accept and popped by a monitor.
module tb_float_floor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_a      = 32'd0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;

  float_floor_if if0 ();
  float_floor_if if1 ();

  assign if0.in_a      = in_a;
  assign if0.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.in_a      = in_a;
  assign if1.in_valid  = in_valid;
  assign if1.out_ready = out_ready;

  float_floor #(.QUIET_NAN(1'b1), .DAZ(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  float_floor #(.QUIET_NAN(1'b0), .DAZ(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    logic [31:0] z;
    logic        ix;
  } res_t;

  res_t q0[$];
  res_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int unexpected = 0;
  int lat_start = -1;
  bit lat_done = 1'b0;
  bit lat_track = 1'b0;
  int run_len = 0;
  int max_run = 0;

  localparam int NV = 20;
  logic [31:0] va  [NV];
  logic [31:0] ez0 [NV];
  logic        ei0 [NV];
  logic [31:0] ez1 [NV];
  logic        ei1 [NV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] z0,
                         input logic i0, input logic [31:0] z1, input logic i1);
    va[i] = a; ez0[i] = z0; ei0[i] = i0; ez1[i] = z1; ei1[i] = i1;
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    res_t r;
    if (rst_n) begin
      if (if0.out_valid && if0.out_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (q0.size() == 0) begin
          checks++; errors++; unexpected++;
          $display("FAIL u0_unexpected: got z=%h with nothing expected", if0.out_z);
        end else begin
          r = q0.pop_front();
          chk("u0_z", {32'd0, if0.out_z}, {32'd0, r.z});
          chk("u0_inexact", {63'd0, if0.out_inexact}, {63'd0, r.ix});
        end
      end else begin
        run_len = 0;
      end
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++; unexpected++;
          $display("FAIL u1_unexpected: got z=%h with nothing expected", if1.out_z);
        end else begin
          r = q1.pop_front();
          chk("u1_z", {32'd0, if1.out_z}, {32'd0, r.z});
          chk("u1_inexact", {63'd0, if1.out_inexact}, {63'd0, r.ix});
        end
      end
      if (lat_start >= 0 && !lat_done && if0.out_valid) begin
        chk("latency", 64'(cyc - lat_start), 64'd3);
        lat_done = 1'b1;
      end
    end
  end

  // Presents vector i and holds it until accepted, then queues its expected results.
  task automatic send(input int i);
    int n = 0;
    bit ok = 1'b0;
    in_a = va[i];
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (if0.in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 for vector %0d", i);
    end else begin
      if (lat_track && lat_start < 0) lat_start = cyc;
      q0.push_back('{z: ez0[i], ix: ei0[i]});
      q1.push_back('{z: ez1[i], ix: ei1[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_q0_empty", 64'(q0.size()), 64'd0);
    chk("drain_q1_empty", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    //         a             u0 z (QN=1,DAZ=0) ix   u1 z (QN=0,DAZ=1) ix
    set_vec(0,  32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b1);
    set_vec(1,  32'hBFC00000, 32'hC0000000, 1'b1, 32'hC0000000, 1'b1);
    set_vec(2,  32'hBE800000, 32'hBF800000, 1'b1, 32'hBF800000, 1'b1);
    set_vec(3,  32'h3E800000, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    set_vec(4,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0);
    set_vec(5,  32'h7F800001, 32'h7FC00001, 1'b0, 32'h7F800001, 1'b0);
    set_vec(6,  32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0);
    set_vec(7,  32'h4B000001, 32'h4B000001, 1'b0, 32'h4B000001, 1'b0);
    set_vec(8,  32'h80000001, 32'hBF800000, 1'b1, 32'h80000000, 1'b0);
    set_vec(9,  32'h4F000000, 32'h4F000000, 1'b0, 32'h4F000000, 1'b0);
    set_vec(10, 32'h40490FDB, 32'h40400000, 1'b1, 32'h40400000, 1'b1);
    set_vec(11, 32'hC0490FDB, 32'hC0800000, 1'b1, 32'hC0800000, 1'b1);
    set_vec(12, 32'hBF800000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0);
    set_vec(13, 32'h3F7FFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    set_vec(14, 32'hBF7FFFFF, 32'hBF800000, 1'b1, 32'hBF800000, 1'b1);
    set_vec(15, 32'h4AFFFFFF, 32'h4AFFFFFE, 1'b1, 32'h4AFFFFFE, 1'b1);
    set_vec(16, 32'hCAFFFFFF, 32'hCB000000, 1'b1, 32'hCB000000, 1'b1);
    set_vec(17, 32'h00000001, 32'h00000000, 1'b1, 32'h00000000, 1'b0);
    set_vec(18, 32'h7FC00000, 32'h7FC00000, 1'b0, 32'h7FC00000, 1'b0);
    set_vec(19, 32'hFF800001, 32'hFFC00001, 1'b0, 32'hFF800001, 1'b0);

    // Reset state
    #1;
    chk("rst_out_valid", {63'd0, if0.out_valid}, 64'd0);
    chk("rst_out_z", {32'd0, if0.out_z}, 64'd0);
    chk("rst_out_inexact", {63'd0, if0.out_inexact}, 64'd0);
    chk("rst_in_ready", {63'd0, if0.in_ready}, 64'd1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values and specials
    for (int i = 0; i < 10; i++) send(i);
    idle();
    drain();

    // Latency and throughput: 8 back-to-back accepts into an empty pipe
    max_run = 0;
    lat_track = 1'b1;
    for (int i = 10; i < 18; i++) send(i);
    idle();
    drain();
    lat_track = 1'b0;
    chk("latency_seen", {63'd0, lat_done}, 64'd1);
    chk("consecutive_outputs", 64'(max_run), 64'd8);

    // Backpressure: fill, stall 5 cycles with a held operand, then resume
    send(18);
    send(19);
    send(0);
    out_ready = 1'b0;
    in_a = va[1];
    in_valid = 1'b1;
    @(negedge clk);
    held = if0.out_z;
    chk("stall_head_z", {32'd0, held}, {32'd0, ez0[18]});
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_in_ready", {63'd0, if0.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, if0.out_valid}, 64'd1);
      chk("stall_out_z", {32'd0, if0.out_z}, {32'd0, held});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1);
    send(2);
    idle();
    drain();

    // Reset with three results in flight
    send(10);
    send(11);
    send(16);
    idle();
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, if0.out_valid}, 64'd0);
    chk("midrst_out_z", {32'd0, if0.out_z}, 64'd0);
    chk("midrst_u1_out_valid", {63'd0, if1.out_valid}, 64'd0);
    q0.delete();
    q1.delete();
    unexpected = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("no_stale_output", 64'(unexpected), 64'd0);
    send(11);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
